// File: rtl/dnn_core_sequencer_pkg.sv
// Shared types and constants for the dnn core sequencer slice.
package dnn_seq_pkg;

  localparam int unsigned DEF_F_SIZE = 1024;
  localparam int unsigned BIAS_ADDR  = DEF_F_SIZE - 1;
  localparam int unsigned PIPE_DRAIN = 2;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    EXEC,
    BIAS,
    DRAIN,
    UPDATE
  } state_t;

endpackage

// File: rtl/dnn_core_sequencer_result_slot.sv
// One-entry valid/ready result register; a capture on the same edge as a pop wins.
module dnn_result_slot #(
  parameter int unsigned DW = 32,
  parameter int unsigned IW = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cap_i,
  input  logic [DW-1:0] cap_data_i,
  input  logic [IW-1:0] cap_idx_i,
  input  logic          ready_i,
  output logic          valid_o,
  output logic [DW-1:0] data_o,
  output logic [IW-1:0] idx_o
);

  logic          valid_q, valid_d;
  logic [DW-1:0] data_q,  data_d;
  logic [IW-1:0] idx_q,   idx_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    idx_d   = idx_q;
    if (cap_i) begin
      valid_d = 1'b1;
      data_d  = cap_data_i;
      idx_d   = cap_idx_i;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      idx_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign idx_o   = idx_q;

endmodule

// File: rtl/dnn_core_sequencer.sv
// Job sequencer for one tiny_dnn_core lane: issues init/exec/bias/update,
// drains the core read pipeline and parks each fp32 result in a one-entry slot.
module dnn_core_sequencer
  import dnn_seq_pkg::*;
#(
  parameter int unsigned F_SIZE     = dnn_seq_pkg::DEF_F_SIZE,
  parameter int unsigned AW         = $clog2(F_SIZE),
  parameter int unsigned PIPE_DRAIN = dnn_seq_pkg::PIPE_DRAIN
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] f_num,
  input  logic [AW-1:0] out_num,
  input  logic          use_bias,
  output logic          busy,
  output logic          done,
  output logic          init,
  output logic          exec,
  output logic          bias,
  output logic          update,
  output logic [AW-1:0] ra,
  output logic [AW-1:0] out_idx,
  output logic          norm_en,
  input  logic [31:0]   nrm,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [31:0]   res_data,
  output logic [AW-1:0] res_idx
);

  localparam int unsigned   DW      = (PIPE_DRAIN > 1) ? $clog2(PIPE_DRAIN) : 1;
  localparam logic [AW-1:0] BIAS_RA = AW'(F_SIZE - 1);

  state_t        state_q;
  logic          busy_q, done_q;
  logic          init_q, exec_q, bias_q, update_q, norm_en_q;
  logic [AW-1:0] ra_q, out_idx_q;
  logic [AW-1:0] f_q, left_q;
  logic          bias_en_q;
  logic [DW-1:0] dcnt_q;
  logic          cap_q, last_q;
  logic [AW-1:0] cap_idx_q;

  logic          more_feat_d, drain_last_d, slot_free_d;

  // ra_q doubles as the feature counter while in EXEC; compared one bit wider so
  // f_num = F_SIZE-1 stops at F_SIZE-2 without wrapping.
  always_comb begin
    more_feat_d  = ({1'b0, ra_q} + (AW+1)'(1)) < {1'b0, f_q};
    drain_last_d = (dcnt_q == DW'(PIPE_DRAIN - 1));
    slot_free_d  = !res_valid || res_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      init_q    <= 1'b0;
      exec_q    <= 1'b0;
      bias_q    <= 1'b0;
      update_q  <= 1'b0;
      norm_en_q <= 1'b0;
      ra_q      <= '0;
      out_idx_q <= '0;
      f_q       <= '0;
      left_q    <= '0;
      bias_en_q <= 1'b0;
      dcnt_q    <= '0;
      cap_q     <= 1'b0;
      last_q    <= 1'b0;
      cap_idx_q <= '0;
    end else begin
      init_q    <= 1'b0;
      exec_q    <= 1'b0;
      bias_q    <= 1'b0;
      update_q  <= 1'b0;
      norm_en_q <= 1'b0;
      done_q    <= 1'b0;
      cap_q     <= 1'b0;
      ra_q      <= '0;

      // The final capture edge is where the job really ends: done and !busy line
      // up with res_valid rising for the last output.
      if (cap_q && last_q) begin
        busy_q <= 1'b0;
        done_q <= 1'b1;
        last_q <= 1'b0;
      end

      unique case (state_q)
        IDLE: begin
          if (start && !busy_q) begin
            if (out_num == '0) begin
              done_q <= 1'b1;
            end else begin
              f_q       <= f_num;
              bias_en_q <= use_bias;
              left_q    <= out_num - AW'(1);
              out_idx_q <= '0;
              busy_q    <= 1'b1;
              init_q    <= 1'b1;
              state_q   <= INIT;
            end
          end
        end

        INIT: begin
          dcnt_q <= '0;
          if (f_q != '0) begin
            exec_q  <= 1'b1;
            state_q <= EXEC;
          end else if (bias_en_q) begin
            bias_q  <= 1'b1;
            ra_q    <= BIAS_RA;
            state_q <= BIAS;
          end else begin
            state_q <= DRAIN;
          end
        end

        EXEC: begin
          if (more_feat_d) begin
            exec_q <= 1'b1;
            ra_q   <= ra_q + AW'(1);
          end else if (bias_en_q) begin
            bias_q  <= 1'b1;
            ra_q    <= BIAS_RA;
            state_q <= BIAS;
          end else begin
            state_q <= DRAIN;
          end
        end

        BIAS: state_q <= DRAIN;

        // Stalling here is safe: with no exec issued the core accumulator holds.
        DRAIN: begin
          if (drain_last_d) begin
            if (slot_free_d) begin
              update_q  <= 1'b1;
              norm_en_q <= 1'b1;
              state_q   <= UPDATE;
            end
          end else begin
            dcnt_q <= dcnt_q + DW'(1);
          end
        end

        UPDATE: begin
          cap_q     <= 1'b1;
          cap_idx_q <= out_idx_q;
          if (left_q != '0) begin
            left_q    <= left_q - AW'(1);
            out_idx_q <= out_idx_q + AW'(1);
            init_q    <= 1'b1;
            state_q   <= INIT;
          end else begin
            last_q  <= 1'b1;
            state_q <= IDLE;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  dnn_result_slot #(
    .DW (32),
    .IW (AW)
  ) u_slot (
    .clk        (clk),
    .rst_n      (rst_n),
    .cap_i      (cap_q),
    .cap_data_i (nrm),
    .cap_idx_i  (cap_idx_q),
    .ready_i    (res_ready),
    .valid_o    (res_valid),
    .data_o     (res_data),
    .idx_o      (res_idx)
  );

  assign busy    = busy_q;
  assign done    = done_q;
  assign init    = init_q;
  assign exec    = exec_q;
  assign bias    = bias_q;
  assign update  = update_q;
  assign ra      = ra_q;
  assign out_idx = out_idx_q;
  assign norm_en = norm_en_q;

endmodule

// File: tb/tb_dnn_core_sequencer.sv
// Bench for dnn_core_sequencer: a small integer core/normalize model feeds nrm,
// expected results go through a scoreboard popped by an independent monitor.
module tb_dnn_core_sequencer;

  localparam int unsigned AW = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] f_num = '0;
  logic [AW-1:0] out_num = '0;
  logic          use_bias = 1'b0;
  logic          busy, done, init, exec, bias, update, norm_en;
  logic [AW-1:0] ra, out_idx, res_idx;
  logic [31:0]   nrm;
  logic          res_valid;
  logic          res_ready = 1'b1;
  logic [31:0]   res_data;

  dnn_core_sequencer #(
    .F_SIZE     (1024),
    .AW         (10),
    .PIPE_DRAIN (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .f_num     (f_num),
    .out_num   (out_num),
    .use_bias  (use_bias),
    .busy      (busy),
    .done      (done),
    .init      (init),
    .exec      (exec),
    .bias      (bias),
    .update    (update),
    .ra        (ra),
    .out_idx   (out_idx),
    .norm_en   (norm_en),
    .nrm       (nrm),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_idx   (res_idx)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;

  typedef struct packed {
    logic [31:0]   d;
    logic [AW-1:0] idx;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Small non-negative integer to fp32.
  function automatic logic [31:0] to_fp(input int unsigned v);
    int p;
    if (v == 0) return 32'h0;
    p = 31;
    while (v[p] == 1'b0) p--;
    return {1'b0, 8'(127 + p), 23'(v << (23 - p))};
  endfunction

  // Core model: strobes and address see the 2-cycle read pipeline.
  // W[o][a] = a + o + 1, features all 1, bias term 1 only at address 1023.
  logic [2:0]    s1, s2;
  logic [AW-1:0] a1, a2, o1, o2;
  int unsigned   acc;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0; s2 <= '0; a1 <= '0; a2 <= '0; o1 <= '0; o2 <= '0;
      acc <= 0; nrm <= '0;
    end else begin
      s1 <= {init, exec, bias};
      a1 <= ra;
      o1 <= out_idx;
      s2 <= s1;
      a2 <= a1;
      o2 <= o1;
      if (s2[2])      acc <= 0;
      else if (s2[1]) acc <= acc + 32'(a2) + 32'(o2) + 1;
      else if (s2[0]) acc <= acc + ((a2 == AW'(1023)) ? 1 : 100);
      if (norm_en) nrm <= to_fp(acc);
    end
  end

  // Monitor: protocol invariants every cycle, scoreboard pop on each transfer.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      chk("strobe_onehot", 64'($countones({init, exec, bias, update}) <= 1), 64'd1);
      if (!exec && !bias) chk("ra_idle_zero", 64'(ra), 64'd0);
      if (done) done_cnt++;
      if (res_valid && res_ready) begin
        chk("result_expected", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("res_data", 64'(res_data), 64'(e.d));
          chk("res_idx", 64'(res_idx), 64'(e.idx));
        end
      end
    end
  end

  logic [7:0] t1v [10] = '{8'h81, 8'h41, 8'h41, 8'h41, 8'h21, 8'h01, 8'h01, 8'h19, 8'h01, 8'h06};
  int         t1r [10] = '{0, 0, 1, 2, 1023, 0, 0, 0, 0, 0};
  logic [7:0] t2v [6]  = '{8'h81, 8'h01, 8'h01, 8'h19, 8'h01, 8'h06};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] d, input int idx);
    exp_t e;
    e.d = d;
    e.idx = AW'(idx);
    sb.push_back(e);
  endtask

  // Leaves the caller just after the edge that sampled start: cycle 0 of the job.
  task automatic launch(input int f, input int o, input logic b);
    f_num = AW'(f);
    out_num = AW'(o);
    use_bias = b;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((busy || res_valid || sb.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    chk("idle_timeout", 64'(n < budget), 64'd1);
    tick();
    tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish required finish before 1ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int d0, cnt;
    logic [31:0] mask;
    logic [7:0]  quiet;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("reset_ctrl", 64'({busy, done, init, exec, bias, update, norm_en, res_valid}), 64'd0);
    chk("reset_ra", 64'(ra), 64'd0);
    chk("reset_out_idx", 64'(out_idx), 64'd0);
    chk("reset_res_data", 64'(res_data), 64'd0);
    chk("reset_res_idx", 64'(res_idx), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // f=3 with bias: 1+2+3+1 = 7.0
    push(32'h40e00000, 0);
    launch(3, 1, 1'b1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("t1_strobes", 64'({init, exec, bias, update, norm_en, res_valid, done, busy}), 64'(t1v[k]));
      chk("t1_ra", 64'(ra), 64'(t1r[k]));
      tick();
    end
    wait_idle(50);

    // f=0, no bias: update at cycle 3, result 0.0
    push(32'h00000000, 0);
    launch(0, 1, 1'b0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("t2_strobes", 64'({init, exec, bias, update, norm_en, res_valid, done, busy}), 64'(t2v[k]));
      tick();
    end
    wait_idle(50);

    // Three outputs back-to-back, f=2: 3.0, 5.0, 7.0; inits at 0, 6, 12
    push(32'h40400000, 0);
    push(32'h40a00000, 1);
    push(32'h40e00000, 2);
    d0 = done_cnt;
    mask = '0;
    launch(2, 3, 1'b0);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (init) mask[k] = 1'b1;
      tick();
    end
    chk("t3_init_cycles", 64'(mask), 64'h1041);
    wait_idle(80);
    chk("t3_done_once", 64'(done_cnt - d0), 64'd1);

    // Downstream stall: second output must wait in DRAIN, first result held
    res_ready = 1'b0;
    push(32'h40000000, 0);
    push(32'h40400000, 1);
    d0 = done_cnt;
    cnt = 0;
    launch(1, 2, 1'b1);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (update) cnt++;
      tick();
    end
    chk("t4_single_update", 64'(cnt), 64'd1);
    chk("t4_no_done_yet", 64'(done_cnt - d0), 64'd0);
    chk("t4_held_valid", 64'(res_valid), 64'd1);
    chk("t4_held_data", 64'(res_data), 64'h40000000);
    chk("t4_held_idx", 64'(res_idx), 64'd0);
    chk("t4_still_busy", 64'(busy), 64'd1);
    res_ready = 1'b1;
    wait_idle(80);
    chk("t4_done_once", 64'(done_cnt - d0), 64'd1);

    // Asynchronous reset in the middle of EXEC, then a clean job
    launch(5, 1, 1'b0);
    tick();
    tick();
    @(negedge clk);
    chk("t5_in_exec", 64'(exec), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("t5_reset_ctrl", 64'({busy, done, init, exec, bias, update, norm_en, res_valid}), 64'd0);
    chk("t5_reset_ra", 64'(ra), 64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    push(32'h40e00000, 0);
    d0 = done_cnt;
    launch(3, 1, 1'b1);
    wait_idle(50);
    chk("t5_clean_done", 64'(done_cnt - d0), 64'd1);

    // start held while busy is ignored, including the final capture cycle
    push(32'h40400000, 0);
    d0 = done_cnt;
    cnt = 0;
    launch(2, 1, 1'b0);
    f_num = AW'(7);
    out_num = AW'(2);
    use_bias = 1'b1;
    start = 1'b1;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      if (init) cnt++;
      tick();
    end
    start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (init) cnt++;
      tick();
    end
    chk("t6_busy_start_ignored", 64'(cnt), 64'd1);
    wait_idle(50);
    chk("t6_done_once", 64'(done_cnt - d0), 64'd1);

    // out_num=0: done one cycle later, nothing else
    d0 = done_cnt;
    launch(5, 0, 1'b1);
    @(negedge clk);
    chk("t6_zero_done", 64'(done), 64'd1);
    chk("t6_zero_busy", 64'(busy), 64'd0);
    quiet = '0;
    for (int k = 0; k < 6; k++) begin
      tick();
      @(negedge clk);
      quiet = quiet | {init, exec, bias, update, norm_en, busy, done, res_valid};
    end
    chk("t6_zero_quiet", 64'(quiet), 64'd0);
    chk("t6_zero_done_count", 64'(done_cnt - d0), 64'd1);

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dnn_core_sequencer.md
Name: dnn_core_sequencer

Overview:
- Control initiator for one tiny_dnn_core lane plus its normalize stage.
- Given a job (feature count, output count, bias enable), issues the init/exec/bias/update strobes and the weight/feature read address `ra`, then pulses the normalize enable.
- Captures the fp32 result into a one-entry valid/ready output slot.
- Absorbs the core's fixed 2-cycle read pipeline so upstream logic only sees a start pulse and a result stream.

Parameters:
- F_SIZE, 1024, core weight-memory depth; address F_SIZE-1 is reserved for the bias.
- AW, 10, address/count width; equals $clog2(F_SIZE).
- PIPE_DRAIN, 2, cycles from the last exec/bias issue until the core accumulator is updated.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  job start pulse; ignored while busy
- f_num  in  AW  features per output, 0..F_SIZE-1; sampled at start
- out_num  in  AW  outputs per job; sampled at start
- use_bias  in  1  add the bias term; sampled at start
- busy  out  1  job in progress
- done  out  1  one-cycle pulse, job finished
- init  out  1  core accumulator clear
- exec  out  1  core multiply-accumulate issue
- bias  out  1  core bias issue
- update  out  1  core result latch / output mux select
- ra  out  AW  read address to core and to the feature buffer (1-cycle synchronous RAM)
- out_idx  out  AW  index of the output being computed; selects the weight bank
- norm_en  out  1  normalize register enable
- nrm  in  32  fp32 result from normalize
- res_valid  out  1  result slot full
- res_ready  in  1  downstream accept
- res_data  out  32  captured fp32 result
- res_idx  out  AW  out_idx of res_data

Behaviour:
- Reset (asynchronous, any time, including mid-job): every output is 0; state = IDLE; latched job fields are cleared.
- States: IDLE, INIT, EXEC, BIAS, DRAIN, UPDATE.
- IDLE: on start with out_num≠0, latch the job, set busy, go to INIT. On start with out_num=0, pulse done in the next cycle, go nowhere, and leave busy low.
- Timing per output is measured relative to its INIT cycle, numbered 0:
  - Cycle 0, INIT: init=1.
  - Cycles 1..F, EXEC: exec=1 and ra=0..F-1. Skipped if F=0.
  - Cycle F+1, BIAS: only if use_bias; bias=1 and ra=F_SIZE-1.
  - L = last issue cycle = F+use_bias (L=0 when both are 0).
  - Cycles L+1..L+2, DRAIN: no strobes.
  - Cycle L+3, UPDATE: update=1 and norm_en=1.
  - Cycle L+4: res_data<=nrm and res_idx<=out_idx at the edge ending this cycle; res_valid is high from L+5.
- UPDATE entry guard: entered only if (!res_valid || res_ready) in the last DRAIN cycle. Otherwise remain in DRAIN; the accumulator holds because no exec is issued.
- After UPDATE:
  - If outputs remain: out_idx++ and go to INIT (back-to-back; the next init reaches the core 2 cycles after update, which is safe).
  - Otherwise go to IDLE after the final capture.
- Throughput: one output every L+4 cycles when unstalled.
- Result slot:
  - Holds while res_valid && !res_ready.
  - Clears on a valid&&ready edge unless a capture occurs on the same edge; in that case the new result wins and valid stays 1.
- done: pulses in the cycle res_valid first rises for the last output. busy falls in the same cycle.
- At most one strobe of init/exec/bias/update is high in any cycle.
- ra is 0 outside EXEC/BIAS.
- Counters:
  - The feature counter compares against f_num with no wrap; f_num=F_SIZE-1 issues addresses 0..F_SIZE-2.
  - out_idx wraps modulo 2^AW (unreachable for legal out_num).

Decomposition:
- Package dnn_seq_pkg: state_t enum (IDLE, INIT, EXEC, BIAS, DRAIN, UPDATE), localparam BIAS_ADDR=F_SIZE-1, PIPE_DRAIN=2.
- Sub-module dnn_result_slot: the one-entry valid/ready register with the capture-wins-over-pop rule. Everything else stays flat.

Test Plan:
- f_num=3, use_bias=1, out_num=1; W={3f80,4000,4040}, bias=3f80, d all 3f80 -> exec cycles 1-3 with ra 0,1,2; bias in cycle 4 with ra 1023; update in cycle 7; res_valid at cycle 9; res_data=40e00000; done same cycle.
- f_num=0, use_bias=0 -> update in cycle 3; res_data=00000000.
- out_num=3, res_ready=1, f_num=2, no bias -> init at cycles 0, 6, 12; res_idx 0,1,2; done once.
- Hold res_ready=0 for 20 cycles, out_num=2 -> second output stalls in DRAIN; no second update until the slot pops; first result is not overwritten.
- rst_n low during EXEC -> all strobes 0 immediately; busy=0. A subsequent start runs a clean job with the correct result.
- start while busy, and start with out_num=0 -> busy start ignored; out_num=0 gives done one cycle later with no strobes.
